// File: rtl/if_id_stage.sv
// IF/ID pipeline register: latches the fetched instruction and PC+4, splits decode fields,
// handles stall/flush with a stall-timeout monitor. Optional counters under `IFID_PERF_CNT_EN.
module if_id_stage #(
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
    parameter logic [7:0]  STALL_MAX = 8'd16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] InstructionIn,
    input  logic [31:0] PCPlus4In,
    input  logic        FetchValid,
    input  logic        Stall,
    input  logic        Flush,
    output logic [31:0] InstructionOut,
    output logic [31:0] PCPlus4Out,
    output logic        ValidOut,
    output logic [5:0]  Opcode,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [4:0]  Shamt,
    output logic [5:0]  Funct,
    output logic [15:0] Imm16,
    output logic [25:0] JumpIndex,
    output logic        StallTimeout
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0] InstrCount,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        HELD  = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic        timeout_q, timeout_d;

    // Flush wins over Stall, Stall wins over a normal load.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        stall_cnt_d = stall_cnt_q;
        if (Flush) begin
            instr_d     = NOP_WORD;
            pc_d        = PCPlus4In;
            state_d     = EMPTY;
            stall_cnt_d = 8'd0;
        end else if (Stall) begin
            stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
            state_d     = (state_q == FULL) ? HELD : state_q;
        end else begin
            instr_d     = FetchValid ? InstructionIn : NOP_WORD;
            pc_d        = PCPlus4In;
            state_d     = FetchValid ? FULL : EMPTY;
            stall_cnt_d = 8'd0;
        end
        timeout_d = (stall_cnt_d >= STALL_MAX);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= EMPTY;
            instr_q     <= NOP_WORD;
            pc_q        <= 32'd0;
            stall_cnt_q <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign InstructionOut = instr_q;
    assign PCPlus4Out     = pc_q;
    assign ValidOut       = (state_q != EMPTY);
    assign StallTimeout   = timeout_q;

    assign Opcode    = instr_q[31:26];
    assign Rs        = instr_q[25:21];
    assign Rt        = instr_q[20:16];
    assign Rd        = instr_q[15:11];
    assign Shamt     = instr_q[10:6];
    assign Funct     = instr_q[5:0];
    assign Imm16     = instr_q[15:0];
    assign JumpIndex = instr_q[25:0];

`ifdef IFID_PERF_CNT_EN
    logic [31:0] instr_cnt_q, stall_cyc_q, flush_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            instr_cnt_q <= 32'd0;
            stall_cyc_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (Flush)
                flush_cnt_q <= sat_inc(flush_cnt_q);
            else if (Stall)
                stall_cyc_q <= sat_inc(stall_cyc_q);
            else if (FetchValid)
                instr_cnt_q <= sat_inc(instr_cnt_q);
        end
    end

    assign InstrCount  = instr_cnt_q;
    assign StallCycles = stall_cyc_q;
    assign FlushCount  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage (built with STALL_MAX=4).
module tb_if_id_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] InstructionIn;
    logic [31:0] PCPlus4In;
    logic        FetchValid;
    logic        Stall;
    logic        Flush;
    logic [31:0] InstructionOut;
    logic [31:0] PCPlus4Out;
    logic        ValidOut;
    logic [5:0]  Opcode;
    logic [4:0]  Rs, Rt, Rd, Shamt;
    logic [5:0]  Funct;
    logic [15:0] Imm16;
    logic [25:0] JumpIndex;
    logic        StallTimeout;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] InstrCount, StallCycles, FlushCount;
`endif

    int checks = 0;
    int errors = 0;

    if_id_stage #(.NOP_WORD(32'h0000_0000), .STALL_MAX(8'd4)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .InstructionIn(InstructionIn), .PCPlus4In(PCPlus4In), .FetchValid(FetchValid),
        .Stall(Stall), .Flush(Flush),
        .InstructionOut(InstructionOut), .PCPlus4Out(PCPlus4Out), .ValidOut(ValidOut),
        .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct),
        .Imm16(Imm16), .JumpIndex(JumpIndex), .StallTimeout(StallTimeout)
`ifdef IFID_PERF_CNT_EN
        , .InstrCount(InstrCount), .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, then settle 1 time unit before checking.
    task automatic cycle(input logic [31:0] instr, input logic [31:0] pc,
                         input logic fv, input logic st, input logic fl);
        InstructionIn = instr;
        PCPlus4In     = pc;
        FetchValid    = fv;
        Stall         = st;
        Flush         = fl;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst_n = 1'b0;
        InstructionIn = 32'hFFFF_FFFF;
        PCPlus4In = 32'h1234_5678;
        FetchValid = 1'b1;
        Stall = 1'b0;
        Flush = 1'b0;
        #2;
        check("reset_instr", InstructionOut, 32'h0);
        check("reset_pc", PCPlus4Out, 32'h0);
        check("reset_valid", 32'(ValidOut), 32'h0);
        check("reset_timeout", 32'(StallTimeout), 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Load addi $8,$9,-4
        cycle(32'h2128_FFFC, 32'h0000_0104, 1'b1, 1'b0, 1'b0);
        check("load_instr", InstructionOut, 32'h2128_FFFC);
        check("load_opcode", 32'(Opcode), 32'h08);
        check("load_rs", 32'(Rs), 32'd9);
        check("load_rt", 32'(Rt), 32'd8);
        check("load_rd", 32'(Rd), 32'd31);
        check("load_shamt", 32'(Shamt), 32'd31);
        check("load_funct", 32'(Funct), 32'h3C);
        check("load_imm16", 32'(Imm16), 32'h0000_FFFC);
        check("load_jidx", 32'(JumpIndex), 32'h0128_FFFC);
        check("load_pc", PCPlus4Out, 32'h0000_0104);
        check("load_valid", 32'(ValidOut), 32'h1);

        // Five stalls with changing inputs: contents hold, timeout after the 4th edge
        for (int i = 1; i <= 5; i++) begin
            cycle(32'hA000_0000 + 32'(i), 32'h0000_0200 + 32'(i), 1'b1, 1'b1, 1'b0);
            check("stall_instr", InstructionOut, 32'h2128_FFFC);
            check("stall_pc", PCPlus4Out, 32'h0000_0104);
            check("stall_valid", 32'(ValidOut), 32'h1);
            check("stall_timeout", 32'(StallTimeout), (i >= 4) ? 32'h1 : 32'h0);
        end

        // Release: add $9,$10,$11
        cycle(32'h014B_4820, 32'h0000_0108, 1'b1, 1'b0, 1'b0);
        check("release_timeout", 32'(StallTimeout), 32'h0);
        check("release_instr", InstructionOut, 32'h014B_4820);
        check("release_rd", 32'(Rd), 32'd9);
        check("release_funct", 32'(Funct), 32'h20);

        // One stall, then Flush+Stall together
        cycle(32'h1111_1111, 32'h0000_010C, 1'b1, 1'b1, 1'b0);
        cycle(32'h2222_2222, 32'h0000_0300, 1'b1, 1'b1, 1'b1);
        check("flush_instr", InstructionOut, 32'h0);
        check("flush_valid", 32'(ValidOut), 32'h0);
        check("flush_pc", PCPlus4Out, 32'h0000_0300);

        // Counter was cleared by the flush: three more stalls stay below the limit
        for (int i = 1; i <= 3; i++) begin
            cycle(32'h3333_3333, 32'h0000_0400, 1'b1, 1'b1, 1'b0);
            check("empty_stall_valid", 32'(ValidOut), 32'h0);
            check("empty_stall_instr", InstructionOut, 32'h0);
        end
        check("flush_cnt_cleared", 32'(StallTimeout), 32'h0);
        cycle(32'h3333_3333, 32'h0000_0400, 1'b1, 1'b1, 1'b0);
        check("empty_timeout", 32'(StallTimeout), 32'h1);

        // FetchValid=0 masks the instruction word
        cycle(32'hDEAD_BEEF, 32'h0000_0500, 1'b0, 1'b0, 1'b0);
        check("nofetch_instr", InstructionOut, 32'h0);
        check("nofetch_valid", 32'(ValidOut), 32'h0);
        check("nofetch_pc", PCPlus4Out, 32'h0000_0500);
        check("nofetch_timeout", 32'(StallTimeout), 32'h0);

        // Async reset mid-cycle while holding a stalled instruction
        cycle(32'h8C22_0010, 32'h0000_0600, 1'b1, 1'b0, 1'b0);
        cycle(32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        check("pre_reset_instr", InstructionOut, 32'h8C22_0010);
        #2;
        Rst_n = 1'b0;
        #1;
        check("async_instr", InstructionOut, 32'h0);
        check("async_pc", PCPlus4Out, 32'h0);
        check("async_valid", 32'(ValidOut), 32'h0);
        check("async_opcode", 32'(Opcode), 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;

`ifdef IFID_PERF_CNT_EN
        check("perf_reset_instr", InstrCount, 32'd0);
        for (int i = 0; i < 10; i++)
            cycle(32'h2000_0000 + 32'(i), 32'h0000_1000 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++)
            cycle(32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        Stall = 1'b1;
        Flush = 1'b0;
        check("perf_instr", InstrCount, 32'd10);
        check("perf_stall", StallCycles, 32'd3);
        check("perf_flush", FlushCount, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
